// File: rtl/control_sequencer.sv
//------------------------------------------------------------------------------
// control_sequencer : multi-cycle fetch/decode/execute sequencer with memory
// wait-state watchdog, conditional jumps and resumable halt.
// Optional build macro: CTRL_SINGLE_STEP_EN (single-step gating after NEXT).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_sequencer #(
  parameter int INSTR_W   = 16,
  parameter int OPC_W     = 5,
  parameter int ADDRM_W   = 3,
  parameter int CYC_W     = 4,
  parameter int RET_W     = 16,
  parameter int STALL_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               mem_ready,
  input  logic [1:0]         flags,
  input  logic               resume,
  input  logic               step,
  output logic [3:0]         state,
  output logic [CYC_W-1:0]   cycle,
  output logic [OPC_W-1:0]   opcode,
  output logic [ADDRM_W-1:0] addrm,
  output logic               mem_req,
  output logic               pc_load,
  output logic               instr_done,
  output logic               halted,
  output logic               fault,
  output logic [RET_W-1:0]   retired
);

  localparam int c_STALL_W = $clog2(STALL_MAX + 1);
  localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(STALL_MAX - 1);

  localparam logic [OPC_W-1:0] c_OP_MOV     = OPC_W'(5'h01);
  localparam logic [OPC_W-1:0] c_OP_LDR     = OPC_W'(5'h02);
  localparam logic [OPC_W-1:0] c_OP_STR     = OPC_W'(5'h03);
  localparam logic [OPC_W-1:0] c_OP_LDI     = OPC_W'(5'h04);
  localparam logic [OPC_W-1:0] c_OP_ALU_LO  = OPC_W'(5'h08);
  localparam logic [OPC_W-1:0] c_OP_ALU_HI  = OPC_W'(5'h10);
  localparam logic [OPC_W-1:0] c_OP_JMP     = OPC_W'(5'h18);
  localparam logic [OPC_W-1:0] c_OP_JZ      = OPC_W'(5'h19);
  localparam logic [OPC_W-1:0] c_OP_JNZ     = OPC_W'(5'h1A);
  localparam logic [OPC_W-1:0] c_OP_JC      = OPC_W'(5'h1B);
  localparam logic [OPC_W-1:0] c_OP_JNC     = OPC_W'(5'h1C);
  localparam logic [OPC_W-1:0] c_OP_HLT     = OPC_W'(5'h1F);

  typedef enum logic [3:0] {
    S_FETCH_PC   = 4'd0,
    S_FETCH_INST = 4'd1,
    S_DECODE     = 4'd2,
    S_MEM_R      = 4'd3,
    S_MEM_W      = 4'd4,
    S_ALU_FETCH  = 4'd5,
    S_ALU_OUT    = 4'd6,
    S_JMP        = 4'd7,
    S_NEXT       = 4'd8,
    S_HALT       = 4'd9,
    S_STEP_WAIT  = 4'd10
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [c_STALL_W-1:0]  r_stall;
  logic [CYC_W-1:0]      r_cycle;
  logic [OPC_W-1:0]      r_opcode;
  logic [ADDRM_W-1:0]    r_addrm;
  logic                  r_fault;
  logic [RET_W-1:0]      r_retired;

  logic                  w_mem_state;
  logic                  w_wait;
  logic                  w_fault_set;
  logic                  w_jump_cond;
  logic                  w_is_rd;
  logic                  w_is_wr;
  logic                  w_is_alu;
  logic                  w_is_jmp;
  logic                  w_is_hlt;
  logic [OPC_W-1:0]      w_fetch_opc;
  logic [ADDRM_W-1:0]    w_fetch_addrm;

  // Low immediate/operand bits and (in the default build) step are not consumed here.
  logic [INSTR_W-OPC_W-ADDRM_W-1:0] w_unused_instr;
  logic                             w_unused_step;
  assign w_unused_instr = instruction[INSTR_W-OPC_W-ADDRM_W-1:0];
  assign w_unused_step  = step;

  assign w_fetch_opc   = instruction[INSTR_W-1 -: OPC_W];
  assign w_fetch_addrm = instruction[INSTR_W-OPC_W-1 -: ADDRM_W];

  assign w_is_rd  = (r_opcode == c_OP_MOV) || (r_opcode == c_OP_LDR);
  assign w_is_wr  = (r_opcode == c_OP_STR) || (r_opcode == c_OP_LDI);
  assign w_is_alu = (r_opcode >= c_OP_ALU_LO) && (r_opcode <= c_OP_ALU_HI);
  assign w_is_jmp = (r_opcode >= c_OP_JMP) && (r_opcode <= c_OP_JNC);
  assign w_is_hlt = (r_opcode == c_OP_HLT);

  assign w_mem_state = (r_state == S_FETCH_INST) || (r_state == S_MEM_R) ||
                       (r_state == S_MEM_W);
  assign w_wait      = w_mem_state && !mem_ready;

  // flags = {C, Z}
  always_comb begin
    w_jump_cond = 1'b0;
    case (r_opcode)
      c_OP_JMP: w_jump_cond = 1'b1;
      c_OP_JZ:  w_jump_cond = flags[0];
      c_OP_JNZ: w_jump_cond = !flags[0];
      c_OP_JC:  w_jump_cond = flags[1];
      c_OP_JNC: w_jump_cond = !flags[1];
      default:  w_jump_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_fault_set = 1'b0;
    case (r_state)
      S_FETCH_PC:   w_next = S_FETCH_INST;
      S_FETCH_INST: if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_rd)       w_next = S_MEM_R;
        else if (w_is_wr)  w_next = S_MEM_W;
        else if (w_is_alu) w_next = S_ALU_FETCH;
        else if (w_is_jmp) w_next = S_JMP;
        else if (w_is_hlt) w_next = S_HALT;
        else               w_next = S_NEXT;
      end
      S_MEM_R:      if (mem_ready) w_next = S_MEM_W;
      S_MEM_W:      if (mem_ready) w_next = S_NEXT;
      S_ALU_FETCH:  w_next = S_ALU_OUT;
      S_ALU_OUT:    w_next = S_NEXT;
      S_JMP:        w_next = S_NEXT;
`ifdef CTRL_SINGLE_STEP_EN
      S_NEXT:       w_next = S_STEP_WAIT;
      S_STEP_WAIT:  if (step) w_next = S_FETCH_PC;
`else
      S_NEXT:       w_next = S_FETCH_PC;
      S_STEP_WAIT:  w_next = S_FETCH_PC;
`endif
      S_HALT:       if (resume && !r_fault) w_next = S_FETCH_PC;
      default:      w_next = S_FETCH_PC;
    endcase
    // Watchdog trips on the STALL_MAX-th consecutive waiting cycle.
    if (w_wait && (r_stall == c_STALL_LAST)) begin
      w_next      = S_HALT;
      w_fault_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH_PC;
      r_stall   <= '0;
      r_cycle   <= '0;
      r_opcode  <= '0;
      r_addrm   <= '0;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;

      if (w_next != r_state)
        r_stall <= '0;
      else if (w_wait)
        r_stall <= r_stall + 1'b1;

      if (w_next == S_FETCH_PC)
        r_cycle <= '0;
      else if ((w_next != r_state) && (r_cycle != '1))
        r_cycle <= r_cycle + 1'b1;

      if ((r_state == S_FETCH_INST) && mem_ready) begin
        r_opcode <= w_fetch_opc;
        r_addrm  <= (w_fetch_opc == c_OP_MOV) ? w_fetch_addrm : '0;
      end

      if (w_fault_set)
        r_fault <= 1'b1;

      if (r_state == S_NEXT && w_next != S_NEXT)
        r_retired <= r_retired + 1'b1;
    end
  end

  assign state      = r_state;
  assign cycle      = r_cycle;
  assign opcode     = r_opcode;
  assign addrm      = r_addrm;
  assign mem_req    = w_mem_state;
  assign pc_load    = (r_state == S_JMP) && w_jump_cond;
  assign instr_done = (r_state == S_NEXT);
  assign halted     = (r_state == S_HALT);
  assign fault      = r_fault;
  assign retired    = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
//------------------------------------------------------------------------------
// tb_control_sequencer : directed self-checking bench for control_sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic        mem_ready;
  logic [1:0]  flags;
  logic        resume;
  logic        step;
  logic [3:0]  state;
  logic [3:0]  cycle;
  logic [4:0]  opcode;
  logic [2:0]  addrm;
  logic        mem_req;
  logic        pc_load;
  logic        instr_done;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  int checks;
  int failures;

  control_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .mem_ready   (mem_ready),
    .flags       (flags),
    .resume      (resume),
    .step        (step),
    .state       (state),
    .cycle       (cycle),
    .opcode      (opcode),
    .addrm       (addrm),
    .mem_req     (mem_req),
    .pc_load     (pc_load),
    .instr_done  (instr_done),
    .halted      (halted),
    .fault       (fault),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check state and cycle, then advance one clock.
  task automatic sc(input string tag, input logic [3:0] st, input logic [3:0] cy);
    chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
    chk({tag, ".cycle"}, {28'd0, cycle}, {28'd0, cy});
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    instruction = 16'h0000;
    mem_ready = 1'b1;
    flags = 2'b00;
    resume = 1'b0;
    step = 1'b0;
    tick();
    tick();

    chk("rst.state", {28'd0, state}, 32'd0);
    chk("rst.cycle", {28'd0, cycle}, 32'd0);
    chk("rst.opcode", {27'd0, opcode}, 32'd0);
    chk("rst.addrm", {29'd0, addrm}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    chk("rst.retired", {16'd0, retired}, 32'd0);
    chk("rst.pc_load", {31'd0, pc_load}, 32'd0);
    chk("rst.instr_done", {31'd0, instr_done}, 32'd0);
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    reset = 1'b0;

    // LDI: 0,1,2,4,8 with cycle 0..4
    instruction = 16'h2000;
    chk("ldi.mreq0", {31'd0, mem_req}, 32'd0);
    sc("ldi.c0", 4'd0, 4'd0);
    chk("ldi.mreq1", {31'd0, mem_req}, 32'd1);
    sc("ldi.c1", 4'd1, 4'd1);
    chk("ldi.opcode", {27'd0, opcode}, 32'h04);
    sc("ldi.c2", 4'd2, 4'd2);
    chk("ldi.mreq_w", {31'd0, mem_req}, 32'd1);
    sc("ldi.c3", 4'd4, 4'd3);
    chk("ldi.done", {31'd0, instr_done}, 32'd1);
    chk("ldi.ret_pre", {16'd0, retired}, 32'd0);
    sc("ldi.c4", 4'd8, 4'd4);
    chk("ldi.done_clr", {31'd0, instr_done}, 32'd0);
    chk("ldi.retired", {16'd0, retired}, 32'd1);

    // MOV with addressing mode 2
    instruction = 16'h0A00;
    sc("mov.c0", 4'd0, 4'd0);
    sc("mov.c1", 4'd1, 4'd1);
    chk("mov.addrm", {29'd0, addrm}, 32'd2);
    chk("mov.opcode", {27'd0, opcode}, 32'h01);
    sc("mov.c2", 4'd2, 4'd2);
    chk("mov.mreq_r", {31'd0, mem_req}, 32'd1);
    sc("mov.c3", 4'd3, 4'd3);
    sc("mov.c4", 4'd4, 4'd4);
    sc("mov.c5", 4'd8, 4'd5);
    chk("mov.retired", {16'd0, retired}, 32'd2);

    // ADD with mem_ready low: ALU states ignore it
    instruction = 16'h4000;
    sc("add.c0", 4'd0, 4'd0);
    sc("add.c1", 4'd1, 4'd1);
    chk("add.addrm", {29'd0, addrm}, 32'd0);
    mem_ready = 1'b0;
    sc("add.c2", 4'd2, 4'd2);
    chk("add.mreq", {31'd0, mem_req}, 32'd0);
    sc("add.c3", 4'd5, 4'd3);
    sc("add.c4", 4'd6, 4'd4);
    mem_ready = 1'b1;
    sc("add.c5", 4'd8, 4'd5);
    chk("add.retired", {16'd0, retired}, 32'd3);

    // JZ with Z=1: taken
    instruction = 16'hC800;
    flags = 2'b01;
    sc("jz1.c0", 4'd0, 4'd0);
    sc("jz1.c1", 4'd1, 4'd1);
    chk("jz1.pcl_dec", {31'd0, pc_load}, 32'd0);
    sc("jz1.c2", 4'd2, 4'd2);
    chk("jz1.pc_load", {31'd0, pc_load}, 32'd1);
    sc("jz1.c3", 4'd7, 4'd3);
    chk("jz1.pcl_next", {31'd0, pc_load}, 32'd0);
    sc("jz1.c4", 4'd8, 4'd4);

    // JZ with Z=0: not taken
    flags = 2'b00;
    sc("jz0.c0", 4'd0, 4'd0);
    sc("jz0.c1", 4'd1, 4'd1);
    sc("jz0.c2", 4'd2, 4'd2);
    chk("jz0.pc_load", {31'd0, pc_load}, 32'd0);
    sc("jz0.c3", 4'd7, 4'd3);
    sc("jz0.c4", 4'd8, 4'd4);

    // JNC with C=0: taken; then C=1 in the same JMP cycle drops it
    instruction = 16'hE000;
    flags = 2'b00;
    sc("jnc.c0", 4'd0, 4'd0);
    sc("jnc.c1", 4'd1, 4'd1);
    sc("jnc.c2", 4'd2, 4'd2);
    chk("jnc.pc_load", {31'd0, pc_load}, 32'd1);
    flags = 2'b10;
    #1;
    chk("jnc.pcl_c1", {31'd0, pc_load}, 32'd0);
    flags = 2'b00;
    sc("jnc.c3", 4'd7, 4'd3);
    sc("jnc.c4", 4'd8, 4'd4);
    chk("jnc.retired", {16'd0, retired}, 32'd6);

    // FETCH_INST stall for 3 cycles (NOP)
    instruction = 16'h0000;
    mem_ready = 1'b0;
    sc("stl.c0", 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stl.mreq", {31'd0, mem_req}, 32'd1);
      sc("stl.hold", 4'd1, 4'd1);
    end
    mem_ready = 1'b1;
    sc("stl.rdy", 4'd1, 4'd1);
    sc("stl.dec", 4'd2, 4'd2);
    sc("stl.next", 4'd8, 4'd3);
    chk("stl.retired", {16'd0, retired}, 32'd7);

    // Watchdog: 15 waiting cycles in FETCH_INST
    instruction = 16'h2000;
    mem_ready = 1'b0;
    sc("wd.c0", 4'd0, 4'd0);
    for (int i = 0; i < 14; i++) begin
      chk("wd.nofault", {31'd0, fault}, 32'd0);
      sc("wd.hold", 4'd1, 4'd1);
    end
    tick();
    chk("wd.state", {28'd0, state}, 32'd9);
    chk("wd.fault", {31'd0, fault}, 32'd1);
    chk("wd.halted", {31'd0, halted}, 32'd1);
    chk("wd.mreq", {31'd0, mem_req}, 32'd0);
    resume = 1'b1;
    tick();
    tick();
    resume = 1'b0;
    chk("wd.res_state", {28'd0, state}, 32'd9);
    chk("wd.res_fault", {31'd0, fault}, 32'd1);
    chk("wd.retired", {16'd0, retired}, 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    chk("wd.rst_state", {28'd0, state}, 32'd0);
    chk("wd.rst_fault", {31'd0, fault}, 32'd0);
    chk("wd.rst_halted", {31'd0, halted}, 32'd0);
    chk("wd.rst_retired", {16'd0, retired}, 32'd0);

    // NOP then HLT: halt does not retire; resume returns to FETCH_PC
    instruction = 16'h0000;
    sc("nop.c0", 4'd0, 4'd0);
    sc("nop.c1", 4'd1, 4'd1);
    sc("nop.c2", 4'd2, 4'd2);
    sc("nop.c3", 4'd8, 4'd3);
    instruction = 16'hF800;
    sc("hlt.c0", 4'd0, 4'd0);
    sc("hlt.c1", 4'd1, 4'd1);
    sc("hlt.c2", 4'd2, 4'd2);
    chk("hlt.state", {28'd0, state}, 32'd9);
    chk("hlt.halted", {31'd0, halted}, 32'd1);
    chk("hlt.fault", {31'd0, fault}, 32'd0);
    chk("hlt.done", {31'd0, instr_done}, 32'd0);
    tick();
    tick();
    chk("hlt.stay", {28'd0, state}, 32'd9);
    chk("hlt.retired", {16'd0, retired}, 32'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("hlt.res_state", {28'd0, state}, 32'd0);
    chk("hlt.res_halted", {31'd0, halted}, 32'd0);

    // Reset during a MEM_R stall
    instruction = 16'h0A00;
    sc("rmr.c0", 4'd0, 4'd0);
    sc("rmr.c1", 4'd1, 4'd1);
    sc("rmr.c2", 4'd2, 4'd2);
    mem_ready = 1'b0;
    sc("rmr.c3", 4'd3, 4'd3);
    chk("rmr.stall", {28'd0, state}, 32'd3);
    chk("rmr.mreq1", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmr.state", {28'd0, state}, 32'd0);
    chk("rmr.mreq0", {31'd0, mem_req}, 32'd0);
    chk("rmr.retired", {16'd0, retired}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
